axi4_lite_mem_responder: RTL and testbench

//  AXI4-Lite subordinate (responder) backed by on-chip byte-maskable RAM; the far end of the
//  AXI4-Lite manager port driven by the memory traffic generator / future DMA-to-AXI converter.

---
 rtl/axi4_lite_pkg.sv | 13 +
 rtl/axi4_lite_mem_responder_mem.sv | 32 +++
 rtl/axi4_lite_mem_responder.sv | 185 ++++++++++++++++++
 tb/tb_axi4_lite_mem_responder.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response encoding used by the memory responder slice.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        e_axi_okay   = 2'b00,
        e_axi_exokay = 2'b01,
        e_axi_slverr = 2'b10,
        e_axi_decerr = 2'b11
    } axi4_lite_resp_e;

    localparam int axi_resp_width_lp = 2;

endpackage

// File: rtl/axi4_lite_mem_responder_mem.sv
// Byte-maskable 1R1W RAM, synchronous write and registered synchronous read.
module bsg_mem_1r1w_sync_mask_write_byte #(
    parameter int els_p        = 1024,
    parameter int data_width_p = 64
) (
    input  logic                        clk_i,
    input  logic                        w_v_i,
    input  logic [$clog2(els_p)-1:0]    w_addr_i,
    input  logic [data_width_p-1:0]     w_data_i,
    input  logic [data_width_p/8-1:0]   w_mask_i,
    input  logic                        r_v_i,
    input  logic [$clog2(els_p)-1:0]    r_addr_i,
    output logic [data_width_p-1:0]     r_data_o
);

    logic [data_width_p-1:0] r_mem [els_p];

    // Read samples the array before this edge's write lands: read-first.
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            for (int b = 0; b < data_width_p/8; b++) begin
                if (w_mask_i[b]) begin
                    r_mem[w_addr_i][8*b +: 8] <= w_data_i[8*b +: 8];
                end
            end
        end
        if (r_v_i) begin
            r_data_o <= r_mem[r_addr_i];
        end
    end

endmodule

// File: rtl/axi4_lite_mem_responder.sv
// AXI4-Lite responder over on-chip RAM; one outstanding read and one write.
module axi4_lite_mem_responder
    import axi4_lite_pkg::*;
#(
    parameter int              addr_width_p  = 28,
    parameter int              data_width_p  = 64,
    parameter int              els_p         = 1024,
    parameter longint unsigned base_addr_p   = 0,
    parameter int              count_width_p = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [addr_width_p-1:0]    awaddr_i,
    input  logic [2:0]                 awprot_i,
    input  logic                       awvalid_i,
    output logic                       awready_o,
    input  logic [data_width_p-1:0]    wdata_i,
    input  logic [data_width_p/8-1:0]  wstrb_i,
    input  logic                       wvalid_i,
    output logic                       wready_o,
    output logic [1:0]                 bresp_o,
    output logic                       bvalid_o,
    input  logic                       bready_i,
    input  logic [addr_width_p-1:0]    araddr_i,
    input  logic [2:0]                 arprot_i,
    input  logic                       arvalid_i,
    output logic                       arready_o,
    output logic [data_width_p-1:0]    rdata_o,
    output logic [1:0]                 rresp_o,
    output logic                       rvalid_o,
    input  logic                       rready_i,
    output logic [count_width_p-1:0]   wr_count_o,
    output logic [count_width_p-1:0]   rd_count_o
);

    localparam int          bytes_lp = data_width_p / 8;
    localparam int          shift_lp = $clog2(bytes_lp);
    localparam int          idx_w_lp = $clog2(els_p);
    localparam logic [63:0] lo_lp    = 64'(base_addr_p);
    localparam logic [63:0] span_lp  = 64'(els_p) << shift_lp;

    typedef enum logic [1:0] {W_COLLECT, W_COMMIT, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ACCESS, R_RESP} r_state_e;

    // Below-base addresses wrap to huge offsets, so one compare covers both ends.
    function automatic logic in_window(input logic [addr_width_p-1:0] a);
        return (64'(a) - lo_lp) < span_lp;
    endfunction

    function automatic logic [idx_w_lp-1:0] word_idx(input logic [addr_width_p-1:0] a);
        return idx_w_lp'((64'(a) - lo_lp) >> shift_lp);
    endfunction

    logic                       r_run;
    w_state_e                   r_w_state;
    w_state_e                   w_w_state_n;
    logic                       r_aw_full;
    logic                       r_w_full;
    logic [addr_width_p-1:0]    r_aw_addr;
    logic [data_width_p-1:0]    r_w_data;
    logic [bytes_lp-1:0]        r_w_strb;
    axi4_lite_resp_e            r_bresp;
    r_state_e                   r_r_state;
    r_state_e                   w_r_state_n;
    logic [addr_width_p-1:0]    r_ar_addr;
    logic                       r_rd_err;
    logic [count_width_p-1:0]   r_wr_count;
    logic [count_width_p-1:0]   r_rd_count;
    logic                       w_aw_hs;
    logic                       w_w_hs;
    logic                       w_b_hs;
    logic                       w_ar_hs;
    logic                       w_r_hs;
    logic                       w_mem_we;
    logic [data_width_p-1:0]    w_mem_rdata;
    logic                       w_unused_prot;

    assign w_unused_prot = ^{awprot_i, arprot_i};

    // r_run keeps every ready low through reset and the first cycle after it.
    assign awready_o  = r_run & ~r_aw_full;
    assign wready_o   = r_run & ~r_w_full;
    assign bvalid_o   = (r_w_state == W_RESP);
    assign bresp_o    = r_bresp;
    assign arready_o  = r_run & (r_r_state == R_IDLE);
    assign rvalid_o   = (r_r_state == R_RESP);
    assign rresp_o    = (rvalid_o && r_rd_err) ? e_axi_decerr : e_axi_okay;
    assign rdata_o    = (rvalid_o && !r_rd_err) ? w_mem_rdata : '0;
    assign wr_count_o = r_wr_count;
    assign rd_count_o = r_rd_count;

    assign w_aw_hs  = awvalid_i & awready_o;
    assign w_w_hs   = wvalid_i & wready_o;
    assign w_b_hs   = bvalid_o & bready_i;
    assign w_ar_hs  = arvalid_i & arready_o;
    assign w_r_hs   = rvalid_o & rready_i;
    assign w_mem_we = (r_w_state == W_COMMIT) & in_window(r_aw_addr);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_w_state <= W_COLLECT;
            r_r_state <= R_IDLE;
        end else begin
            r_w_state <= w_w_state_n;
            r_r_state <= w_r_state_n;
        end
    end

    always_comb begin
        w_w_state_n = r_w_state;
        unique case (r_w_state)
            W_COLLECT: if (r_aw_full && r_w_full) w_w_state_n = W_COMMIT;
            W_COMMIT:  w_w_state_n = W_RESP;
            W_RESP:    if (bready_i) w_w_state_n = W_COLLECT;
            default:   w_w_state_n = W_COLLECT;
        endcase
    end

    always_comb begin
        w_r_state_n = r_r_state;
        unique case (r_r_state)
            R_IDLE:   if (w_ar_hs) w_r_state_n = R_ACCESS;
            R_ACCESS: w_r_state_n = R_RESP;
            R_RESP:   if (rready_i) w_r_state_n = R_IDLE;
            default:  w_r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_run      <= 1'b0;
            r_aw_full  <= 1'b0;
            r_w_full   <= 1'b0;
            r_bresp    <= e_axi_okay;
            r_rd_err   <= 1'b0;
            r_wr_count <= '0;
            r_rd_count <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_b_hs) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_full <= 1'b1;
                if (w_w_hs)  r_w_full  <= 1'b1;
            end
            if (r_w_state == W_COMMIT) begin
                r_bresp <= in_window(r_aw_addr) ? e_axi_okay : e_axi_decerr;
            end
            if (r_r_state == R_ACCESS) begin
                r_rd_err <= ~in_window(r_ar_addr);
            end
            if (w_b_hs && (r_wr_count != '1)) begin
                r_wr_count <= r_wr_count + count_width_p'(1);
            end
            if (w_r_hs && (r_rd_count != '1)) begin
                r_rd_count <= r_rd_count + count_width_p'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_aw_hs) r_aw_addr <= awaddr_i;
        if (w_w_hs) begin
            r_w_data <= wdata_i;
            r_w_strb <= wstrb_i;
        end
        if (w_ar_hs) r_ar_addr <= araddr_i;
    end

    bsg_mem_1r1w_sync_mask_write_byte #(
        .els_p        (els_p),
        .data_width_p (data_width_p)
    ) u_mem (
        .clk_i    (clk_i),
        .w_v_i    (w_mem_we),
        .w_addr_i (word_idx(r_aw_addr)),
        .w_data_i (r_w_data),
        .w_mask_i (r_w_strb),
        .r_v_i    (r_r_state == R_ACCESS),
        .r_addr_i (word_idx(r_ar_addr)),
        .r_data_o (w_mem_rdata)
    );

endmodule

// File: tb/tb_axi4_lite_mem_responder.sv
// Self-checking bench: vector table, handshake corner sequences, random vs model.
module tb_axi4_lite_mem_responder;

    localparam int AW   = 28;
    localparam int CW   = 8;
    localparam int ELS  = 1024;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [AW-1:0] WIN_END = AW'(ELS * 8);

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready;
    logic [63:0]   wdata, rdata;
    logic [7:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          bvalid, bready, arvalid, arready, rvalid, rready;
    logic [CW-1:0] wr_count, rd_count;

    always #5 clk = ~clk;

    axi4_lite_mem_responder #(.count_width_p(CW)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .awaddr_i(awaddr), .awprot_i(awprot),
        .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wstrb_i(wstrb),
        .wvalid_i(wvalid), .wready_o(wready),
        .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
        .araddr_i(araddr), .arprot_i(arprot),
        .arvalid_i(arvalid), .arready_o(arready),
        .rdata_o(rdata), .rresp_o(rresp),
        .rvalid_o(rvalid), .rready_i(rready),
        .wr_count_o(wr_count), .rd_count_o(rd_count)
    );

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [63:0]   data;
        logic [7:0]    strb;
        logic [63:0]   exp_data;
        logic [1:0]    exp_resp;
    } vec_t;

    vec_t        tbl [15];
    logic [63:0] model_mem [ELS];
    logic [9:0]  pool [8];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_wr   = 0;
    int          exp_rd   = 0;
    logic [63:0] got_d, exp_d, d64;
    logic [1:0]  got_r, exp_r;
    logic [AW-1:0] a;
    logic [7:0]  s;
    logic        seen_b, seen_r;
    int          n_tw, n_tr;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: handshake did not occur within bound", nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic logic [1:0] model_write(input logic [AW-1:0] ad,
                                               input logic [63:0] d,
                                               input logic [7:0] st);
        logic [9:0] w;
        if (ad >= WIN_END) return 2'b11;
        w = 10'(ad >> 3);
        for (int b = 0; b < 8; b++)
            if (st[b]) model_mem[w][b*8 +: 8] = d[b*8 +: 8];
        return 2'b00;
    endfunction

    task automatic do_write(input logic [AW-1:0] ad, input logic [63:0] d,
                            input logic [7:0] st, input int dly,
                            output logic [1:0] resp);
        logic aw_ok, w_ok, aw_hs, w_hs, b_ok;
        awaddr = ad; wdata = d; wstrb = st;
        awvalid = 1'b1; wvalid = 1'b1;
        aw_ok = 1'b0; w_ok = 1'b0;
        for (int k = 0; k < 20 && !(aw_ok && w_ok); k++) begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            step();
            if (aw_hs) begin awvalid = 1'b0; aw_ok = 1'b1; end
            if (w_hs)  begin wvalid  = 1'b0; w_ok  = 1'b1; end
        end
        if (!(aw_ok && w_ok)) begin
            timeout("wr_accept");
            awvalid = 1'b0; wvalid = 1'b0;
        end
        repeat (dly) step();
        bready = 1'b1; b_ok = 1'b0; resp = 2'bxx;
        for (int k = 0; k < 20 && !b_ok; k++) begin
            @(negedge clk);
            if (bvalid) begin b_ok = 1'b1; resp = bresp; end
            step();
        end
        bready = 1'b0;
        if (b_ok) exp_wr++;
        else timeout("b_wait");
    endtask

    task automatic do_read(input logic [AW-1:0] ad, input int dly,
                           output logic [63:0] d, output logic [1:0] resp);
        logic ok, hs;
        araddr = ad; arvalid = 1'b1; ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            hs = arready;
            step();
            if (hs) begin arvalid = 1'b0; ok = 1'b1; end
        end
        if (!ok) begin timeout("rd_accept"); arvalid = 1'b0; end
        repeat (dly) step();
        rready = 1'b1; ok = 1'b0; d = 'x; resp = 2'bxx;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (rvalid) begin ok = 1'b1; d = rdata; resp = rresp; end
            step();
        end
        rready = 1'b0;
        if (ok) exp_rd++;
        else timeout("r_wait");
    endtask

    task automatic check_quiet(input string nm);
        check({nm, "_ctl"}, 64'({awready, wready, arready, bvalid, rvalid}), 64'd0);
        check({nm, "_resp"}, 64'({bresp, rresp}), 64'd0);
        check({nm, "_rdata"}, rdata, 64'd0);
        check({nm, "_cnt"}, 64'({wr_count, rd_count}), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = 3'd0; arprot = 3'd0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        wdata = '0; wstrb = '0; bready = 1'b0; rready = 1'b0;

        tbl[0]  = '{1'b1, 28'h10,      64'hDEADBEEF_CAFEF00D, 8'hFF, 64'h0, 2'd0};
        tbl[1]  = '{1'b0, 28'h10,      64'h0, 8'h00, 64'hDEADBEEF_CAFEF00D, 2'd0};
        tbl[2]  = '{1'b1, 28'h10,      64'h11223344_55667788, 8'h0F, 64'h0, 2'd0};
        tbl[3]  = '{1'b0, 28'h10,      64'h0, 8'h00, 64'hDEADBEEF_55667788, 2'd0};
        tbl[4]  = '{1'b1, 28'h0,       64'h01234567_89ABCDEF, 8'hFF, 64'h0, 2'd0};
        tbl[5]  = '{1'b1, 28'h2000,    64'hFFFFFFFF_FFFFFFFF, 8'hFF, 64'h0, 2'd3};
        tbl[6]  = '{1'b0, 28'h2000,    64'h0, 8'h00, 64'h0, 2'd3};
        tbl[7]  = '{1'b0, 28'h0,       64'h0, 8'h00, 64'h01234567_89ABCDEF, 2'd0};
        tbl[8]  = '{1'b1, 28'h10,      64'hFFFFFFFF_FFFFFFFF, 8'h00, 64'h0, 2'd0};
        tbl[9]  = '{1'b0, 28'h17,      64'h0, 8'h00, 64'hDEADBEEF_55667788, 2'd0};
        tbl[10] = '{1'b1, 28'h1B,      64'hA5A5A5A5_5A5A5A5A, 8'hFF, 64'h0, 2'd0};
        tbl[11] = '{1'b0, 28'h18,      64'h0, 8'h00, 64'hA5A5A5A5_5A5A5A5A, 2'd0};
        tbl[12] = '{1'b0, 28'hFFFFFFF, 64'h0, 8'h00, 64'h0, 2'd3};
        tbl[13] = '{1'b1, 28'h1FF8,    64'h0BADF00D_12345678, 8'hFF, 64'h0, 2'd0};
        tbl[14] = '{1'b0, 28'h1FFF,    64'h0, 8'h00, 64'h0BADF00D_12345678, 2'd0};

        repeat (3) step();
        check_quiet("reset");
        reset_n = 1'b1;
        step();
        check("post_reset_ready", 64'({awready, wready, arready}), 64'd7);

        n_tw = 0; n_tr = 0;
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].is_wr) begin
                do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, i % 3, got_r);
                check($sformatf("vec%0d_bresp", i), 64'(got_r), 64'(tbl[i].exp_resp));
                n_tw++;
            end else begin
                do_read(tbl[i].addr, i % 2, got_d, got_r);
                check($sformatf("vec%0d_rdata", i), got_d, tbl[i].exp_data);
                check($sformatf("vec%0d_rresp", i), 64'(got_r), 64'(tbl[i].exp_resp));
                n_tr++;
            end
        end
        check("vec_wr_count", 64'(wr_count), 64'(sat(n_tw)));
        check("vec_rd_count", 64'(rd_count), 64'(sat(n_tr)));

        // W three cycles ahead of AW, then a second pair held during B stall
        wdata = 64'h11112222_33334444; wstrb = 8'hFF; wvalid = 1'b1;
        @(negedge clk);
        check("ord_wready_first", 64'(wready), 64'd1);
        step();
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ord_w_held_wready", 64'(wready), 64'd0);
            check("ord_w_held_bvalid", 64'(bvalid), 64'd0);
            step();
        end
        awaddr = 28'h40; awvalid = 1'b1;
        @(negedge clk);
        check("ord_awready", 64'(awready), 64'd1);
        step();
        awvalid = 1'b0;
        seen_b = 1'b0;
        for (int k = 0; k < 10 && !seen_b; k++) begin
            @(negedge clk);
            if (bvalid) seen_b = 1'b1;
            step();
        end
        check("ord_bvalid_rise", 64'(seen_b), 64'd1);
        awaddr = 28'h48; wdata = 64'h55556666_77778888;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ord_stall_bvalid", 64'(bvalid), 64'd1);
            check("ord_stall_readies", 64'({awready, wready}), 64'd0);
            check("ord_stall_bresp", 64'(bresp), 64'd0);
            step();
        end
        bready = 1'b1;
        @(negedge clk);
        check("ord_b_hs", 64'(bvalid), 64'd1);
        step();
        bready = 1'b0;
        exp_wr++;
        do_write(28'h48, 64'h55556666_77778888, 8'hFF, 0, got_r);
        check("ord_second_bresp", 64'(got_r), 64'd0);
        do_read(28'h40, 0, got_d, got_r);
        check("ord_first_data", got_d, 64'h11112222_33334444);
        do_read(28'h48, 0, got_d, got_r);
        check("ord_second_data", got_d, 64'h55556666_77778888);
        check("ord_wr_count", 64'(wr_count), 64'(sat(exp_wr)));

        // AR latency and R backpressure
        do_write(28'h80, 64'hC0FFEE00_12345678, 8'hFF, 0, got_r);
        araddr = 28'h80; arvalid = 1'b1;
        @(negedge clk);
        check("lat_arready", 64'(arready), 64'd1);
        step();
        arvalid = 1'b0;
        check("lat_n1_rvalid", 64'(rvalid), 64'd0);
        step();
        check("lat_n2_rvalid", 64'(rvalid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("lat_stall_rvalid", 64'(rvalid), 64'd1);
            check("lat_stall_rdata", rdata, 64'hC0FFEE00_12345678);
            check("lat_stall_arready", 64'(arready), 64'd0);
            step();
        end
        rready = 1'b1;
        @(negedge clk);
        check("lat_r_hs", 64'(rvalid), 64'd1);
        step();
        rready = 1'b0;
        exp_rd++;
        check("lat_after_hs", 64'({arready, rvalid}), 64'b10);

        // Commit and RAM read of the same word land in the same cycle
        do_write(28'h90, 64'h0000_0000_0000_0A1D, 8'hFF, 0, got_r);
        awaddr = 28'h90; wdata = 64'h0000_0000_0000_0E3E; wstrb = 8'hFF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        check("rf_aw_w_ready", 64'({awready, wready}), 64'd3);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 28'h90; arvalid = 1'b1;
        @(negedge clk);
        check("rf_arready", 64'(arready), 64'd1);
        step();
        arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        seen_b = 1'b0; seen_r = 1'b0; got_d = 'x;
        for (int k = 0; k < 10 && !(seen_b && seen_r); k++) begin
            @(negedge clk);
            if (bvalid && bready) seen_b = 1'b1;
            if (rvalid && rready) begin seen_r = 1'b1; got_d = rdata; end
            step();
            if (seen_b) bready = 1'b0;
            if (seen_r) rready = 1'b0;
        end
        bready = 1'b0; rready = 1'b0;
        if (seen_b) exp_wr++; else timeout("rf_b");
        if (seen_r) exp_rd++; else timeout("rf_r");
        check("rf_old_data", got_d, 64'h0000_0000_0000_0A1D);
        do_read(28'h90, 0, got_d, got_r);
        check("rf_new_data", got_d, 64'h0000_0000_0000_0E3E);

        // Random traffic against the array model
        for (int i = 0; i < 8; i++) begin
            pool[i] = 10'(64 + i * 37);
            d64 = {$urandom(), $urandom()};
            exp_r = model_write({15'd0, pool[i], 3'd0}, d64, 8'hFF);
            do_write({15'd0, pool[i], 3'd0}, d64, 8'hFF, 0, got_r);
            check("rnd_init_bresp", 64'(got_r), 64'(exp_r));
        end
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0)
                a = AW'(32'h2000 + $urandom_range(0, 32'h0FFF_DFFF));
            else
                a = {15'd0, pool[$urandom_range(0, 7)], 3'($urandom())};
            if ($urandom_range(0, 1) == 1) begin
                d64 = {$urandom(), $urandom()};
                s = 8'($urandom());
                exp_r = model_write(a, d64, s);
                do_write(a, d64, s, int'($urandom_range(0, 3)), got_r);
                check($sformatf("rnd%0d_bresp@%h", i, a), 64'(got_r), 64'(exp_r));
            end else begin
                exp_d = (a >= WIN_END) ? 64'd0 : model_mem[10'(a >> 3)];
                exp_r = (a >= WIN_END) ? 2'b11 : 2'b00;
                do_read(a, int'($urandom_range(0, 3)), got_d, got_r);
                check($sformatf("rnd%0d_rdata@%h", i, a), got_d, exp_d);
                check($sformatf("rnd%0d_rresp@%h", i, a), 64'(got_r), 64'(exp_r));
            end
        end
        check("rnd_wr_count", 64'(wr_count), 64'(sat(exp_wr)));
        check("rnd_rd_count", 64'(rd_count), 64'(sat(exp_rd)));

        // Reset with both response channels stalled
        awaddr = 28'hA0; wdata = 64'h1; wstrb = 8'hFF; araddr = 28'h10;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(negedge clk);
        check("mid_accept", 64'({awready, wready, arready}), 64'd7);
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        repeat (4) step();
        check("mid_both_valid", 64'({bvalid, rvalid}), 64'd3);
        reset_n = 1'b0;
        step();
        check_quiet("mid_reset");
        reset_n = 1'b1;
        step();
        exp_wr = 0; exp_rd = 0;
        check("mid_cnt_zero", 64'({wr_count, rd_count}), 64'd0);
        do_read(28'h10, 0, got_d, got_r);
        check("mid_ram_kept_10", got_d, 64'hDEADBEEF_55667788);
        do_read(28'h0, 0, got_d, got_r);
        check("mid_ram_kept_0", got_d, 64'h01234567_89ABCDEF);

        while (exp_rd < CMAX) do_read(28'h0, 0, got_d, got_r);
        check("sat_at_max", 64'(rd_count), 64'(CMAX));
        while (exp_rd < CMAX + 4) do_read(28'h0, 0, got_d, got_r);
        check("sat_held", 64'(rd_count), 64'(sat(exp_rd)));
        check("sat_last_data", got_d, 64'h01234567_89ABCDEF);
        check("sat_wr_count", 64'(wr_count), 64'(sat(exp_wr)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
